seq_divider: RTL and testbench
==============================

# seq_divider

Sequential signed divider, the inverse companion to the team's Booth multiplier. Takes a WIDTH-bit signed dividend and divisor on a one-cycle `start` pulse and produces a truncating quotient and remainder after a fixed WIDTH+1 cycles. It uses restoring division on operand magnitudes, one quotient bit per cycle, then applies a final sign-fix cycle. It shares the multiplier's start/valid handshake, so the same benches and control FSMs can drive either block.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width (two's complement); must be ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; asynchronous and active-high.
- `start`  input  1  request; sampled only while idle.
- `X`  input  WIDTH  signed dividend; sampled at the accepting edge only.
- `Y`  input  WIDTH  signed divisor; sampled at the accepting edge only.
- `busy`  output  1  high from the accepting edge until the edge that raises `valid`.
- `valid`  output  1  one-cycle completion pulse.
- `Q`  output  WIDTH  signed quotient; holds until the next completion.
- `R`  output  WIDTH  signed remainder; holds until the next completion.
- `dz`  output  1  divide-by-zero flag for the current result.
- `ovf`  output  1  overflow flag for the current result (most-negative / -1).

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start`=1:
  - Latch |X| and |Y| as WIDTH-bit unsigned values (|−2^(WIDTH−1)| fits).
  - Latch sign bits, dz = (Y==0), and the original X.
  - Clear the partial remainder (WIDTH+1 bits) and the step counter.
  - Go to CALC.
- CALC, each edge:
  - Shift {rem, quo} left by 1, bringing in the next dividend bit (MSB first).
  - If rem ≥ |Y|: rem −= |Y| and quotient bit = 1; otherwise quotient bit = 0.
  - After exactly WIDTH steps, go to FIX.
- FIX, one edge:
  - Q = (sX^sY) ? −quo : quo, truncated to WIDTH bits.
  - R = sX ? −rem : rem. The remainder takes the dividend's sign; the quotient truncates toward zero; X = Q·Y + R.
  - Set valid=1 and busy=0, then go to IDLE.
- dz: the datapath still runs for WIDTH steps, but FIX overrides the result: Q = all ones, R = original X, dz=1, ovf=0.
- ovf: set when X = −2^(WIDTH−1) and Y = −1. Q = −2^(WIDTH−1) (the natural wrap), R=0.
- `dz` and `ovf` are updated only at FIX and held with Q/R.
- `start` while busy is ignored; the in-flight operation is unaffected.
- Changing X/Y after the accepting edge has no effect.

## Timing
- Reset (async, any time): state IDLE. busy, valid, Q, R, dz and ovf are all 0. An in-flight operation is aborted and no `valid` is produced.
- Accept edge E0 (start=1 in IDLE): busy=1 after E0.
- CALC steps occur at E1..E_WIDTH; FIX occurs at E_(WIDTH+1).
- `valid` is high for exactly one cycle after E_(WIDTH+1); latency is WIDTH+1 cycles (9 at the default).
- busy falls at the same edge that raises valid.
- Back-to-back: a `start` held high during the valid cycle is accepted at the next edge (IDLE).
- `start` held continuously re-triggers every WIDTH+2 cycles.
- Q, R and flags change only on the valid edge or on reset.

## Test plan
- Reset, then X=62, Y=7, 1-cycle start -> valid exactly 9 cycles later; Q=8, R=6, dz=0, ovf=0; busy high for 9 cycles.
- X=34, Y=−9 -> Q=−3, R=7. X=−18, Y=−10 -> Q=1, R=−8. X=−7, Y=2 -> Q=−3, R=−1.
- X=−128, Y=−1 -> Q=−128 (8'h80), R=0, ovf=1. X=−128, Y=1 -> Q=−128, ovf=0.
- X=12, Y=0 -> Q=8'hFF, R=12, dz=1, latency still 9.
- Pulse start again at cycle 3 of a busy operation with different operands -> ignored, first result unchanged. Start asserted in the valid cycle -> second result 9 cycles after its acceptance.
- Assert rst at CALC step 4 -> outputs 0 immediately, no valid pulse. The next start after release completes normally.

Source files
------------

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Sequential signed divider (companion to the Booth multiplier). Accepts a
// WIDTH-bit signed dividend/divisor on a one-cycle start pulse and returns a
// truncating quotient and a remainder that carries the dividend's sign.
// Restoring division runs on the operand magnitudes, one quotient bit per
// cycle, followed by a single sign-fix cycle. Latency is WIDTH+1 cycles.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   request, sampled only while idle
//   X      in   signed dividend, sampled at the accepting edge
//   Y      in   signed divisor, sampled at the accepting edge
//   busy   out  high from the accepting edge until the valid edge
//   valid  out  one-cycle completion pulse
//   Q      out  signed quotient, held until the next completion
//   R      out  signed remainder, held until the next completion
//   dz     out  divide-by-zero flag for the current result
//   ovf    out  overflow flag (most-negative / -1) for the current result
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] X,
  input  logic signed [WIDTH-1:0] Y,
  output logic                    busy,
  output logic                    valid,
  output logic signed [WIDTH-1:0] Q,
  output logic signed [WIDTH-1:0] R,
  output logic                    dz,
  output logic                    ovf
);

  localparam int                  CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]    MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  // Control state (reset)
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sx_q;
  logic             sy_q;
  logic             dz_op_q;

  // Datapath state (no reset; always loaded at the accepting edge)
  logic [WIDTH-1:0] quo_q;    // holds |X| initially, shifts out dividend bits and in quotient bits
  logic [WIDTH-1:0] absy_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] xorig_q;

  // Step datapath
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;

  // Magnitude of a two's complement value. The most-negative value maps to
  // 2^(WIDTH-1), which is representable as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's complement negation, truncated to WIDTH bits.
  function automatic logic [WIDTH-1:0] apply_sign(input logic neg,
                                                  input logic [WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // The shifted partial remainder needs WIDTH+1 bits for the compare. The
  // difference always lands below |Y|, so its low WIDTH bits are exact.
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, absy_q});
    rem_sub = rem_sh[WIDTH-1:0] - absy_q;
  end

  // ---- Datapath registers ----
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (start) begin
          quo_q   <= mag(X);
          absy_q  <= mag(Y);
          rem_q   <= '0;
          xorig_q <= X;
        end
      end
      CALC: begin
        quo_q <= {quo_q[WIDTH-2:0], ge};
        rem_q <= ge ? rem_sub : rem_sh[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // ---- Control FSM and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      dz_op_q <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      Q       <= '0;
      R       <= '0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sx_q    <= X[WIDTH-1];
            sy_q    <= Y[WIDTH-1];
            dz_op_q <= (Y == '0);
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (dz_op_q) begin
            // Division by zero: all-ones quotient, dividend passed through.
            Q   <= '1;
            R   <= xorig_q;
            dz  <= 1'b1;
            ovf <= 1'b0;
          end else begin
            // MOST_NEG / -1 wraps naturally to MOST_NEG; only flag it.
            Q   <= apply_sign(sx_q ^ sy_q, quo_q);
            R   <= apply_sign(sx_q, rem_q);
            dz  <= 1'b0;
            ovf <= (xorig_q == MOST_NEG) && sy_q && (absy_q == WIDTH'(1));
          end
          valid   <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [7:0] X;
  logic signed [7:0] Y;
  logic              busy;
  logic              valid;
  logic signed [7:0] Q;
  logic signed [7:0] R;
  logic              dz;
  logic              ovf;

  int errs   = 0;
  int checks = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .busy  (busy),
    .valid (valid),
    .Q     (Q),
    .R     (R),
    .dz    (dz),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present operands with a one-cycle start; scramble inputs after acceptance.
  task automatic launch(input string tag, input int x, input int y);
    @(negedge clk);
    X     = 8'(x);
    Y     = 8'(y);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    X     = 8'sh5A;
    Y     = 8'sh03;
    chk({tag, "_busy_accept"}, busy, 1);
  endtask

  // Wait (bounded) for valid; expect it after exp_lat more edges.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    bit bz;
    lat = 0;
    bz  = 1'b1;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid) break;
      if (!busy) bz = 1'b0;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_held"}, bz, 1);
    chk({tag, "_busy_fall"}, busy, 0);
  endtask

  task automatic chk_out(input string tag, input int q, input int r,
                         input int dzx, input int ovx);
    chk({tag, "_Q"}, Q, q);
    chk({tag, "_R"}, R, r);
    chk({tag, "_dz"}, dz, dzx);
    chk({tag, "_ovf"}, ovf, ovx);
  endtask

  task automatic chk_hold(input string tag, input int q);
    @(posedge clk);
    #1;
    chk({tag, "_valid_pulse"}, valid, 0);
    chk({tag, "_Q_hold"}, Q, q);
  endtask

  task automatic run(input string tag, input int x, input int y, input int q,
                     input int r, input int dzx, input int ovx);
    launch(tag, x, y);
    wait_done(tag, 9);
    chk_out(tag, q, r, dzx, ovx);
    chk_hold(tag, q);
  endtask

  initial begin
    bit saw_valid;
    rst   = 1'b1;
    start = 1'b0;
    X     = '0;
    Y     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk_out("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    run("d62_7",    62,    7,    8,  6, 0, 0);
    run("d34_m9",   34,   -9,   -3,  7, 0, 0);
    run("dm18_m10", -18, -10,    1, -8, 0, 0);
    run("dm7_2",    -7,    2,   -3, -1, 0, 0);
    run("dm128_m1", -128, -1, -128,  0, 0, 1);
    run("dm128_1",  -128,  1, -128,  0, 0, 0);
    run("d12_0",    12,    0,   -1, 12, 1, 0);

    // Start pulse during a busy operation is ignored
    launch("ign", 62, 7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    X     = -8'sd100;
    Y     = 8'sd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", 6);
    chk_out("ign", 8, 6, 0, 0);
    chk_hold("ign", 8);

    // Back-to-back: start raised during the valid cycle
    launch("b2b1", 34, -9);
    wait_done("b2b1", 9);
    chk_out("b2b1", -3, 7, 0, 0);
    X     = -8'sd7;
    Y     = 8'sd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b2_busy_accept", busy, 1);
    chk("b2b2_Q_hold_accept", Q, -3);
    wait_done("b2b2", 9);
    chk_out("b2b2", -3, -1, 0, 0);

    // Reset in the middle of CALC aborts the operation
    launch("abort", 62, 7);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk_out("abort", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (valid) saw_valid = 1'b1;
    end
    chk("abort_no_valid", saw_valid, 0);
    run("post_rst", 100, -7, -14, 2, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
